smi_frame_tx: RTL and testbench

SMI_FRAME_TX -- requirements
Module: smi_frame_tx

---
 rtl/smi_frame_pkg.sv | 35 +++
 rtl/smi_flit_out_reg.sv | 43 ++++
 rtl/smi_frame_tx.sv | 89 ++++++++
 tb/tb_smi_frame_tx.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_frame_pkg.sv
// Shared definitions for the SMI frame transmitter: EOFC encoding, FSM state
// enum and the frame-length to flit-count arithmetic.
package smi_frame_pkg;

    localparam logic [7:0] EOFC_NONE = 8'd0;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StXfer = 1'b1
    } frameState_e;

    // ceil(log2(flitWidth)); flitWidth is a power of two in 1..64.
    function automatic int flitLog2(input int flitWidth);
        int result;
        result = 0;
        for (int i = 0; i < 7; i++) begin
            if ((1 << i) < flitWidth) result = i + 1;
        end
        return result;
    endfunction

    function automatic logic [31:0] flitCount(input logic [31:0] byteLength,
                                              input int flitWidth);
        return (byteLength + 32'(flitWidth) - 32'd1) >> flitLog2(flitWidth);
    endfunction

    // Valid bytes in the final flit: 1..flitWidth, never 0.
    function automatic logic [7:0] tailByteCount(input logic [31:0] byteLength,
                                                 input int flitWidth);
        logic [7:0] remainder;
        remainder = 8'(byteLength & 32'(flitWidth - 1));
        return (remainder == 8'd0) ? 8'(flitWidth) : remainder;
    endfunction

endpackage

// File: rtl/smi_flit_out_reg.sv
// Single-entry valid/stop output register carrying one SMI flit and its EOFC.
// Loading while the held flit is stalled is prevented by the caller.
module smi_flit_out_reg
    import smi_frame_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load,
    input  logic [DataWidth-1:0] loadData,
    input  logic [7:0]           loadEofc,
    output logic                 outValid,
    output logic [DataWidth-1:0] outData,
    output logic [7:0]           outEofc,
    input  logic                 outStop
);

    logic                 validQ;
    logic [DataWidth-1:0] dataQ;
    logic [7:0]           eofcQ;

    // NOTE: data and eofc are reset as well as valid, so dataOut reads zero after srst.
    always_ff @(posedge clk) begin
        if (srst) begin
            validQ <= 1'b0;
            dataQ  <= '0;
            eofcQ  <= EOFC_NONE;
        end else if (load) begin
            validQ <= 1'b1;
            dataQ  <= loadData;
            eofcQ  <= loadEofc;
        end else if (outValid && !outStop) begin
            validQ <= 1'b0;
        end
    end

    // Outputs read as reset values for the whole time srst is high.
    assign outValid = validQ & ~srst;
    assign outData  = srst ? '0 : dataQ;
    assign outEofc  = srst ? EOFC_NONE : eofcQ;

endmodule

// File: rtl/smi_frame_tx.sv
// SMI frame transmitter: accepts a frame-length command, then forwards that
// many bytes of payload flits through one output register, marking the tail.
module smi_frame_tx
    import smi_frame_pkg::*;
#(
    parameter int FlitWidth   = 8,
    parameter int LengthWidth = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   cmdValid,
    input  logic [LengthWidth-1:0] cmdLength,
    output logic                   cmdStop,
    input  logic                   payloadValid,
    input  logic [FlitWidth*8-1:0] payload,
    output logic                   payloadStop,
    output logic                   dataOutValid,
    output logic [7:0]             dataOutEofc,
    output logic [FlitWidth*8-1:0] dataOut,
    input  logic                   dataOutStop,
    output logic                   lengthError
);

    localparam int FlitLog2   = flitLog2(FlitWidth);
    localparam int CountWidth = LengthWidth - FlitLog2 + 1;
    localparam int DataWidth  = FlitWidth * 8;

    localparam logic [0:0] IDLE = StIdle;
    localparam logic [0:0] XFER = StXfer;

    logic [0:0]            state;
    logic [CountWidth-1:0] flitCnt;
    logic [7:0]            tailBytes;
    logic                  lengthErrorQ;
    logic                  cmdXfer;
    logic                  payloadXfer;
    logic                  lastFlit;
    logic [7:0]            loadEofc;

    assign cmdStop     = ~srst & (state == XFER);
    // A new flit may enter only when the output register is free or draining.
    assign payloadStop = srst | (state == IDLE) | (dataOutValid & dataOutStop);
    assign cmdXfer     = cmdValid & ~cmdStop;
    assign payloadXfer = payloadValid & ~payloadStop;
    assign lastFlit    = (flitCnt == CountWidth'(1));
    assign loadEofc    = lastFlit ? tailBytes : EOFC_NONE;
    assign lengthError = lengthErrorQ & ~srst;

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= IDLE;
            flitCnt      <= '0;
            tailBytes    <= EOFC_NONE;
            lengthErrorQ <= 1'b0;
        end else begin
            lengthErrorQ <= 1'b0;
            if (state == IDLE) begin
                if (cmdXfer) begin
                    if (cmdLength == '0) begin
                        lengthErrorQ <= 1'b1;
                    end else begin
                        flitCnt   <= CountWidth'(flitCount(32'(cmdLength), FlitWidth));
                        tailBytes <= tailByteCount(32'(cmdLength), FlitWidth);
                        state     <= XFER;
                    end
                end
            end else if (payloadXfer) begin
                // flitCnt >= 1 throughout XFER, so this never wraps.
                flitCnt <= flitCnt - CountWidth'(1);
                if (lastFlit) state <= IDLE;
            end
        end
    end

    smi_flit_out_reg #(
        .DataWidth(DataWidth)
    ) uOutReg (
        .clk      (clk),
        .srst     (srst),
        .load     (payloadXfer),
        .loadData (payload),
        .loadEofc (loadEofc),
        .outValid (dataOutValid),
        .outData  (dataOut),
        .outEofc  (dataOutEofc),
        .outStop  (dataOutStop)
    );

endmodule

// File: tb/tb_smi_frame_tx.sv
// Directed bench for smi_frame_tx: a queue-based frame model feeds a per-cycle
// output checker; directed sequences pin EOFC values, latency and reset.
module tb_smi_frame_tx;

    localparam int FW = 8;
    localparam int DW = FW * 8;

    logic          clk;
    logic          srst;
    logic          cmdValid;
    logic [15:0]   cmdLength;
    logic          cmdStop;
    logic          payloadValid;
    logic [DW-1:0] payload;
    logic          payloadStop;
    logic          dataOutValid;
    logic [7:0]    dataOutEofc;
    logic [DW-1:0] dataOut;
    logic          dataOutStop;
    logic          lengthError;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stallLeft = 0;
    int stallCount = 0;
    logic [DW-1:0] stallData = '0;

    logic [DW-1:0] expData[$];
    logic [7:0]    expEofc[$];
    logic [7:0]    logEofc[$];
    int            logCyc[$];
    int            acceptCyc[$];

    smi_frame_tx #(.FlitWidth(FW), .LengthWidth(16)) dut (
        .clk          (clk),
        .srst         (srst),
        .cmdValid     (cmdValid),
        .cmdLength    (cmdLength),
        .cmdStop      (cmdStop),
        .payloadValid (payloadValid),
        .payload      (payload),
        .payloadStop  (payloadStop),
        .dataOutValid (dataOutValid),
        .dataOutEofc  (dataOutEofc),
        .dataOut      (dataOut),
        .dataOutStop  (dataOutStop),
        .lengthError  (lengthError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake bound expired", name);
    endtask

    // Payload pattern: byte b of flit idx in frame fid = b + fid*16 + idx.
    function automatic logic [DW-1:0] pat(input int fid, input int idx);
        return 64'h0706050403020100 + 64'h0101010101010101 * 64'((fid << 4) | idx);
    endfunction

    // Advance one clock; downstream stop is driven here so it has a single writer.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (stallLeft > 0 && dataOutValid && dataOut == stallData) begin
            dataOutStop = 1'b1;
            stallLeft--;
        end else begin
            dataOutStop = 1'b0;
        end
    endtask

    // Output checker: every transfer must match the model queue; a stalled flit must hold.
    initial begin
        logic          holdPrev;
        logic [DW-1:0] prevData;
        logic [7:0]    prevEofc;
        holdPrev = 1'b0;
        prevData = '0;
        prevEofc = '0;
        forever begin
            @(negedge clk);
            if (srst) begin
                holdPrev = 1'b0;
            end else begin
                if (holdPrev) begin
                    check("hold valid", 64'(dataOutValid), 64'd1);
                    check("hold data", dataOut, prevData);
                    check("hold eofc", 64'(dataOutEofc), 64'(prevEofc));
                end
                if (dataOutValid && dataOutStop) begin
                    check("payloadStop while stalled", 64'(payloadStop), 64'd1);
                    stallCount++;
                end
                if (dataOutValid && !dataOutStop) begin
                    if (expData.size() == 0) begin
                        check("unexpected flit", 64'(dataOutValid), 64'd0);
                    end else begin
                        check("flit data", dataOut, expData.pop_front());
                        check("flit eofc", 64'(dataOutEofc), 64'(expEofc.pop_front()));
                        logEofc.push_back(dataOutEofc);
                        logCyc.push_back(cyc);
                    end
                end
                holdPrev = dataOutValid && dataOutStop;
                prevData = dataOut;
                prevEofc = dataOutEofc;
            end
        end
    end

    // Model: a frame of len bytes is ceil(len/FW) flits; only the last carries
    // the count of bytes left over after the full flits.
    task automatic runFrame(input int len, input int fid);
        int n;
        int i;
        int budget;
        n = (len + FW - 1) / FW;
        for (int k = 0; k < n; k++) begin
            expData.push_back(pat(fid, k));
            expEofc.push_back(8'((k == n - 1) ? len - (n - 1) * FW : 0));
        end
        cmdValid  = 1'b1;
        cmdLength = 16'(len);
        if (len != 0) begin
            payloadValid = 1'b1;
            payload      = pat(fid, 0);
        end
        budget = 0;
        @(negedge clk);
        while (cmdStop && budget < 200) begin
            stepCycle();
            @(negedge clk);
            budget++;
        end
        if (cmdStop) begin
            timeout("command accept");
            cmdValid     = 1'b0;
            payloadValid = 1'b0;
            return;
        end
        stepCycle();
        cmdValid = 1'b0;
        i = 0;
        budget = 0;
        while (len != 0 && i < n && budget < 500) begin
            @(negedge clk);
            if (budget == 0) check("cmdStop in frame", 64'(cmdStop), 64'd1);
            if (payloadValid && !payloadStop) begin
                acceptCyc.push_back(cyc);
                i++;
            end
            stepCycle();
            budget++;
            if (i < n) payload = pat(fid, i);
            else payloadValid = 1'b0;
        end
        if (i < n) begin
            timeout("payload accept");
            payloadValid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (expData.size() != 0 && budget < 100) begin
            stepCycle();
            budget++;
        end
        if (expData.size() != 0) timeout("output drain");
        @(negedge clk);
        check("valid cleared after frame", 64'(dataOutValid), 64'd0);
        stepCycle();
    endtask

    task automatic clearLogs();
        logEofc.delete();
        logCyc.delete();
        acceptCyc.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " cmdStop"}, 64'(cmdStop), 64'd0);
        check({tag, " payloadStop"}, 64'(payloadStop), 64'd1);
        check({tag, " dataOutValid"}, 64'(dataOutValid), 64'd0);
        check({tag, " dataOutEofc"}, 64'(dataOutEofc), 64'd0);
        check({tag, " dataOut"}, dataOut, 64'd0);
        check({tag, " lengthError"}, 64'(lengthError), 64'd0);
    endtask

    initial begin
        int budget;
        logic accepted;
        srst         = 1'b1;
        cmdValid     = 1'b0;
        cmdLength    = '0;
        payloadValid = 1'b0;
        payload      = '0;
        dataOutStop  = 1'b0;
        stepCycle();
        stepCycle();
        @(negedge clk);
        checkResetOutputs("reset");
        stepCycle();
        srst = 1'b0;
        stepCycle();

        // 20 bytes: three flits back to back, one cycle after acceptance.
        clearLogs();
        runFrame(20, 1);
        drain();
        check("20B flit count", 64'(logEofc.size()), 64'd3);
        if (logEofc.size() == 3) begin
            check("20B eofc0", 64'(logEofc[0]), 64'd0);
            check("20B eofc1", 64'(logEofc[1]), 64'd0);
            check("20B eofc2", 64'(logEofc[2]), 64'd4);
            check("20B consecutive 1", 64'(logCyc[1] - logCyc[0]), 64'd1);
            check("20B consecutive 2", 64'(logCyc[2] - logCyc[1]), 64'd1);
            for (int k = 0; k < 3; k++)
                check("20B latency", 64'(logCyc[k] - acceptCyc[k]), 64'd1);
        end

        // 16 bytes: two full flits, command port reopens the cycle after the last load.
        clearLogs();
        runFrame(16, 2);
        @(negedge clk);
        check("16B cmdStop after last load", 64'(cmdStop), 64'd0);
        drain();
        check("16B flit count", 64'(logEofc.size()), 64'd2);
        if (logEofc.size() == 2) begin
            check("16B eofc0", 64'(logEofc[0]), 64'd0);
            check("16B eofc1", 64'(logEofc[1]), 64'd8);
        end

        // Zero-length command.
        cmdValid  = 1'b1;
        cmdLength = 16'd0;
        @(negedge clk);
        check("zero cmd accepted", 64'(cmdStop), 64'd0);
        check("lengthError before", 64'(lengthError), 64'd0);
        stepCycle();
        cmdValid = 1'b0;
        @(negedge clk);
        check("lengthError pulse", 64'(lengthError), 64'd1);
        check("zero cmd no flit", 64'(dataOutValid), 64'd0);
        stepCycle();
        @(negedge clk);
        check("lengthError one cycle", 64'(lengthError), 64'd0);
        check("zero cmd stays idle", 64'(cmdStop), 64'd0);
        check("zero cmd no flit later", 64'(dataOutValid), 64'd0);
        stepCycle();

        // 32 bytes with flit 2 stalled for three cycles.
        clearLogs();
        stallData  = pat(4, 1);
        stallLeft  = 3;
        stallCount = 0;
        runFrame(32, 4);
        drain();
        check("stall cycles", 64'(stallCount), 64'd3);
        check("stall consumed", 64'(stallLeft), 64'd0);
        check("stall flit count", 64'(logEofc.size()), 64'd4);
        if (logEofc.size() == 4) check("stall last eofc", 64'(logEofc[3]), 64'd8);

        // Reset mid-frame after the first flit of a 24-byte frame.
        clearLogs();
        expData.push_back(pat(5, 0));
        expEofc.push_back(8'd0);
        cmdValid     = 1'b1;
        cmdLength    = 16'd24;
        payloadValid = 1'b1;
        payload      = pat(5, 0);
        @(negedge clk);
        check("reset test cmd accepted", 64'(cmdStop), 64'd0);
        stepCycle();
        cmdValid = 1'b0;
        budget   = 0;
        accepted = 1'b0;
        while (!accepted && budget < 50) begin
            @(negedge clk);
            accepted = payloadValid && !payloadStop;
            stepCycle();
            budget++;
        end
        if (!accepted) timeout("reset test payload");
        payload = pat(5, 1);
        @(negedge clk);
        stepCycle();
        srst         = 1'b1;
        payloadValid = 1'b0;
        @(negedge clk);
        checkResetOutputs("during srst");
        stepCycle();
        srst = 1'b0;
        @(negedge clk);
        checkResetOutputs("after srst");
        for (int k = 0; k < 5; k++) stepCycle();
        check("reset flit 1 delivered", 64'(logEofc.size()), 64'd1);
        check("reset model flushed", 64'(expData.size()), 64'd0);
        clearLogs();
        runFrame(1, 6);
        drain();
        check("1B flit count", 64'(logEofc.size()), 64'd1);
        if (logEofc.size() == 1) check("1B eofc", 64'(logEofc[0]), 64'd1);

        // Back-to-back 9-byte and 8-byte frames.
        clearLogs();
        runFrame(9, 7);
        runFrame(8, 8);
        drain();
        check("b2b flit count", 64'(logEofc.size()), 64'd3);
        if (logEofc.size() == 3) begin
            check("b2b eofc0", 64'(logEofc[0]), 64'd0);
            check("b2b eofc1", 64'(logEofc[1]), 64'd1);
            check("b2b eofc2", 64'(logEofc[2]), 64'd8);
            check("b2b idle gap", 64'(logCyc[2] - logCyc[1] <= 2), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
